// File: rtl/instr_encoder_if.sv
// Field-bundle / instruction-word bus between a producer and instr_encoder.
// Optional per-word parity appears when INSTR_ENCODER_PARITY_EN is defined.
interface instr_encoder_if;
  // Handshake: a bundle transfers on a rising edge where in_valid && in_ready;
  // a word transfers on a rising edge where out_valid && out_ready. The sender
  // holds its payload stable while valid is high and the transfer has not yet happened.
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [25:0] jaddr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] imemload;
  logic [31:0] out_addr;
  logic [15:0] word_count;
  logic        err;
  logic        done;
  logic        clear;
`ifdef INSTR_ENCODER_PARITY_EN
  logic        out_parity;
`endif

  modport master (
    output in_valid, fmt, opcode, func, rs, rt, rd, shamt, imm, jaddr,
    output out_ready, clear,
`ifdef INSTR_ENCODER_PARITY_EN
    input  out_parity,
`endif
    input  in_ready, out_valid, imemload, out_addr, word_count, err, done
  );

  modport slave (
    input  in_valid, fmt, opcode, func, rs, rt, rd, shamt, imm, jaddr,
    input  out_ready, clear,
`ifdef INSTR_ENCODER_PARITY_EN
    output out_parity,
`endif
    output in_ready, out_valid, imemload, out_addr, word_count, err, done
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs MIPS R/I/J fields into 32-bit words, buffers them in a FIFO and streams
// them out with byte addresses; closes input after HALT. Option: INSTR_ENCODER_PARITY_EN.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic             CLK,
  input  logic             RST,
  instr_encoder_if.slave   bus,
  output logic [1:0]       state_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_J   = 2'd2;
  localparam logic [1:0] FMT_ILL = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_WAIT = 2'd1,
    ST_DONE      = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   wcnt_q, wcnt_d;
  logic          err_q, err_d;
  logic          full, empty, accept, push, pop, wr_en;
  logic [31:0]   enc_word;

  always_comb begin
    enc_word = 32'h0;
    case (bus.fmt)
      FMT_R:   enc_word = {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.func};
      FMT_I:   enc_word = {bus.opcode, bus.rs, bus.rt, bus.imm};
      FMT_J:   enc_word = {bus.opcode, bus.jaddr};
      default: enc_word = 32'h0;
    endcase
  end

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  // Readiness looks only at registered occupancy, so a same-cycle pop never frees a slot early.
  assign bus.in_ready  = !full && (state_q == ST_RUN);
  assign bus.out_valid = !empty;
  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && (bus.fmt != FMT_ILL);
  assign pop    = bus.out_valid && bus.out_ready;
  assign wr_en  = push && !bus.clear;

  assign bus.imemload   = mem_q[rd_ptr_q];
  assign bus.out_addr   = addr_q;
  assign bus.word_count = wcnt_q;
  assign bus.err        = err_q;
  assign bus.done       = (state_q == ST_DONE);
  assign state_o        = state_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    wcnt_d   = wcnt_q;
    err_d    = err_q;
    state_d  = state_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      addr_d   = addr_q + 32'd4;
      if (wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (accept && (bus.fmt == FMT_ILL)) err_d = 1'b1;

    // Input is closed after HALT, so the HALT word is always the last one buffered.
    case (state_q)
      ST_RUN:       if (push && (bus.opcode == OP_HALT)) state_d = ST_HALT_WAIT;
      ST_HALT_WAIT: if (pop && (count_q == CW'(1)))      state_d = ST_DONE;
      ST_DONE:      state_d = ST_DONE;
      default:      state_d = ST_RUN;
    endcase

    if (bus.clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      addr_d   = BASE_ADDR;
      wcnt_d   = 16'h0;
      err_d    = 1'b0;
      state_d  = ST_RUN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDR;
      wcnt_q   <= 16'h0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      wcnt_q   <= wcnt_d;
      err_q    <= err_d;
      if (wr_en) mem_q[wr_ptr_q] <= enc_word;
    end
  end

`ifdef INSTR_ENCODER_PARITY_EN
  logic par_q [DEPTH];

  assign bus.out_parity = par_q[rd_ptr_q];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) par_q[i] <= 1'b0;
    end else if (wr_en) begin
      par_q[wr_ptr_q] <= ^enc_word;
    end
  end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus a randomized
// run checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_instr_encoder;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;
  int         errors = 0;
  int         checks = 0;

  instr_encoder_if bus();

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .CLK     (clk),
    .RST     (rst),
    .bus     (bus),
    .state_o (state_dbg)
  );

  always #5 clk = ~clk;

  // Reference model: queue of words not yet emitted plus scalar status.
  logic [31:0] exp_q[$];
  logic [31:0] m_addr;
  logic [15:0] m_wcnt;
  logic        m_err;
  logic        m_closed;
  logic        m_done;

  function automatic logic [31:0] ref_encode(input logic [1:0] f, input logic [5:0] op,
      input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
      input logic [5:0] fn, input logic [15:0] im, input logic [25:0] ja);
    logic [31:0] w;
    w = 32'(op) << 26;
    if (f == 2'd0) w = w | (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | (32'(sh) << 6) | 32'(fn);
    else if (f == 2'd1) w = w | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
    else w = w | 32'(ja);
    return w;
  endfunction

  function automatic logic m_ready();
    return (exp_q.size() < DEPTH) && !m_closed && !m_done;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_addr = BASE; m_wcnt = 16'h0; m_err = 1'b0; m_closed = 1'b0; m_done = 1'b0;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.clear = 1'b0;
  endtask

  task automatic drive(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
      input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
      input logic [15:0] im, input logic [25:0] ja);
    bus.in_valid = 1'b1; bus.fmt = f; bus.opcode = op; bus.rs = s; bus.rt = t;
    bus.rd = d; bus.shamt = sh; bus.func = fn; bus.imm = im; bus.jaddr = ja;
  endtask

  // Advance one clock with current inputs and update the model; returns #1 after the edge.
  task automatic step();
    logic acc, pp;
    acc = bus.in_valid && m_ready();
    pp  = (exp_q.size() != 0) && bus.out_ready;
    @(posedge clk);
    if (rst || bus.clear) begin
      model_reset();
    end else begin
      if (pp) begin
        exp_q.delete(0);
        m_addr = m_addr + 32'd4;
        if (m_wcnt != 16'hFFFF) m_wcnt = m_wcnt + 16'd1;
        if (m_closed && exp_q.size() == 0) m_done = 1'b1;
      end
      if (acc) begin
        if (bus.fmt == 2'd3) m_err = 1'b1;
        else begin
          exp_q.push_back(ref_encode(bus.fmt, bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt,
                                     bus.func, bus.imm, bus.jaddr));
          if (bus.opcode == 6'h3F) m_closed = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic pulse_clear();
    idle(); bus.clear = 1'b1; step(); bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); bus.out_ready = 1'b0;
    step(); step();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.imemload !== 32'h0) begin errors++; $display("FAIL reset_imemload: got %h want 0", bus.imemload); end
    checks++; if (bus.out_addr !== BASE) begin errors++; $display("FAIL reset_out_addr: got %h want %h", bus.out_addr, BASE); end
    checks++; if (bus.word_count !== 16'h0) begin errors++; $display("FAIL reset_word_count: got %h want 0", bus.word_count); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
`ifdef INSTR_ENCODER_PARITY_EN
    checks++; if (bus.out_parity !== 1'b0) begin errors++; $display("FAIL reset_parity: got %b want 0", bus.out_parity); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_rtype();
    bus.out_ready = 1'b1;
    drive(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0);
    step(); idle();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rtype_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.imemload !== 32'h0022_1821) begin errors++; $display("FAIL rtype_word: got %h want 00221821", bus.imemload); end
    checks++; if (bus.out_addr !== 32'h0) begin errors++; $display("FAIL rtype_addr: got %h want 0", bus.out_addr); end
    step();
    checks++; if (bus.word_count !== 16'd1) begin errors++; $display("FAIL rtype_count: got %0d want 1", bus.word_count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rtype_empty: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_ij_hold();
    pulse_clear();
    bus.out_ready = 1'b0;
    drive(2'd1, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0);
    step();
    drive(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000010);
    step(); idle();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.imemload !== 32'h2022_FFFF) begin errors++; $display("FAIL ij_hold_word: got %h want 2022ffff", bus.imemload); end
      checks++; if (bus.out_addr !== 32'h0) begin errors++; $display("FAIL ij_hold_addr: got %h want 0", bus.out_addr); end
      step();
    end
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.imemload !== 32'h0800_0010) begin errors++; $display("FAIL ij_jword: got %h want 08000010", bus.imemload); end
    checks++; if (bus.out_addr !== 32'h4) begin errors++; $display("FAIL ij_jaddr: got %h want 4", bus.out_addr); end
    step();
    checks++; if (bus.word_count !== 16'd2) begin errors++; $display("FAIL ij_count: got %0d want 2", bus.word_count); end
  endtask

  task automatic test_full();
    logic [31:0] words [DEPTH+1];
    pulse_clear();
    bus.out_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      drive(2'd0, 6'h00, 5'(i), 5'(i + 7), 5'(i + 1), 5'(i), 6'h20, 16'h0, 26'h0);
      words[i] = ref_encode(2'd0, 6'h00, 5'(i), 5'(i + 7), 5'(i + 1), 5'(i), 6'h20, 16'h0, 26'h0);
      step();
      checks++;
      if (bus.in_ready !== (i < DEPTH - 1)) begin
        errors++; $display("FAIL full_in_ready[%0d]: got %b want %b", i, bus.in_ready, (i < DEPTH - 1));
      end
    end
    idle(); bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (bus.imemload !== words[i]) begin errors++; $display("FAIL full_word[%0d]: got %h want %h", i, bus.imemload, words[i]); end
      checks++; if (bus.out_addr !== 32'(4 * i)) begin errors++; $display("FAIL full_addr[%0d]: got %h want %h", i, bus.out_addr, 32'(4 * i)); end
      step();
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_drained: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_illegal();
    pulse_clear();
    bus.out_ready = 1'b1;
    drive(2'd3, 6'h3F, 5'd1, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 26'h1);
    step(); idle();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b want 1", bus.err); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL illegal_no_word: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL illegal_in_ready: got %b want 1", bus.in_ready); end
    step();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b want 1", bus.err); end
    pulse_clear();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL illegal_clear: got %b want 0", bus.err); end
  endtask

  task automatic test_halt();
    pulse_clear();
    bus.out_ready = 1'b0;
    drive(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0);
    step();
    drive(2'd2, 6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);
    step(); idle();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL halt_closed: got %b want 0", bus.in_ready); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL halt_early_done: got %b want 0", bus.done); end
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL halt_mid_done: got %b want 0", bus.done); end
    checks++; if (bus.imemload !== 32'hFC00_0000) begin errors++; $display("FAIL halt_word: got %h want fc000000", bus.imemload); end
    step();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL halt_done: got %b want 1", bus.done); end
    checks++; if (bus.word_count !== 16'd2) begin errors++; $display("FAIL halt_count: got %0d want 2", bus.word_count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL halt_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL halt_done_ready: got %b want 0", bus.in_ready); end
    pulse_clear();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL halt_clear_done: got %b want 0", bus.done); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL halt_clear_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_addr !== BASE) begin errors++; $display("FAIL halt_clear_addr: got %h want %h", bus.out_addr, BASE); end
  endtask

  task automatic test_reset_mid();
    pulse_clear();
    bus.out_ready = 1'b1;
    drive(2'd1, 6'h0D, 5'd4, 5'd5, 5'd0, 5'd0, 6'h0, 16'h00FF, 26'h0);
    step(); step(); idle(); step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(2'd1, 6'h09, 5'(i), 5'(i), 5'd0, 5'd0, 6'h0, 16'(i), 26'h0);
      step();
    end
    idle();
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.word_count !== 16'h0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", bus.word_count); end
    checks++; if (bus.out_addr !== BASE) begin errors++; $display("FAIL rstmid_addr: got %h want %h", bus.out_addr, BASE); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_random();
    pulse_clear();
    for (int n = 0; n < 600; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.fmt       = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      bus.opcode    = ($urandom_range(0, 24) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
      bus.rs        = 5'($urandom);
      bus.rt        = 5'($urandom);
      bus.rd        = 5'($urandom);
      bus.shamt     = 5'($urandom);
      bus.func      = 6'($urandom);
      bus.imm       = 16'($urandom);
      bus.jaddr     = 26'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.clear     = ($urandom_range(0, 79) == 0) || (m_done && $urandom_range(0, 3) == 0);
      step();
      checks++; if (bus.out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, bus.out_valid, (exp_q.size() != 0)); end
      if (exp_q.size() != 0) begin
        checks++; if (bus.imemload !== exp_q[0]) begin errors++; $display("FAIL rnd_word[%0d]: got %h want %h", n, bus.imemload, exp_q[0]); end
`ifdef INSTR_ENCODER_PARITY_EN
        checks++; if (bus.out_parity !== ^exp_q[0]) begin errors++; $display("FAIL rnd_parity[%0d]: got %b want %b", n, bus.out_parity, ^exp_q[0]); end
`endif
      end
      checks++; if (bus.out_addr !== m_addr) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, bus.out_addr, m_addr); end
      checks++; if (bus.word_count !== m_wcnt) begin errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", n, bus.word_count, m_wcnt); end
      checks++; if (bus.err !== m_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b want %b", n, bus.err, m_err); end
      checks++; if (bus.done !== m_done) begin errors++; $display("FAIL rnd_done[%0d]: got %b want %b", n, bus.done, m_done); end
      checks++; if (bus.in_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, bus.in_ready, m_ready()); end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.clear = 1'b0; bus.out_ready = 1'b0;
    bus.fmt = 2'd0; bus.opcode = 6'h0; bus.func = 6'h0; bus.rs = 5'h0; bus.rt = 5'h0;
    bus.rd = 5'h0; bus.shamt = 5'h0; bus.imm = 16'h0; bus.jaddr = 26'h0;
    model_reset();
    #2;
    test_reset();
    test_rtype();
    test_ij_hold();
    test_full();
    test_illegal();
    test_halt();
    test_reset_mid();
    test_random();
    $display("final state_o=%0d", state_dbg);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Packs decoded instruction fields (opcode, rs, rt, rd, shamt, func, imm, jump address) back into 32-bit MIPS instruction words. This is the inverse of the control unit's instruction decode.
- Buffers the encoded words in a small FIFO and streams them out with a valid/ready handshake, each word tagged with a sequential word address.
- Used by test infrastructure and the program loader to feed instruction memory.
- Tracks HALT: once a HALT word has been accepted, input is closed until the halt has drained.

Parameters:
- DEPTH, 4, output FIFO entries (power of two, ≥2)
- BASE_ADDR, 32'h0000_0000, address tagged to the first emitted word

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- fmt  in  2  0=R-type, 1=I-type, 2=J-type, 3=illegal
- opcode  in  6  opcode field
- func  in  6  R-type function field
- rs, rt, rd  in  5 each  register fields
- shamt  in  5  shift amount
- imm  in  16  immediate
- jaddr  in  26  jump target field
- out_valid  out  1  imemload/out_addr hold a word
- out_ready  in  1  consumer accepts the word
- imemload  out  32  encoded instruction word
- out_addr  out  32  byte address of this word
- word_count  out  16  words emitted since reset/clear
- err  out  1  sticky: illegal fmt seen
- done  out  1  HALT emitted and FIFO empty
- clear  in  1  restart after done; resets address, count, err, state

Behaviour:
- Encoding:
  - R: {opcode,rs,rt,rd,shamt,func}
  - I: {opcode,rs,rt,imm}
  - J: {opcode,jaddr}
  - Unused fields are ignored.
- Accept occurs on in_valid && in_ready.
  - fmt=3: no push; err set (sticky) on that edge; in_ready unaffected.
- in_ready = !full && state==RUN. Availability freed by a same-cycle pop is not counted.
- Pop occurs on out_valid && out_ready.
  - out_addr advances by 4 after each pop.
  - word_count increments after each pop, saturating at 16'hFFFF.
- out_valid = !empty. imemload and out_addr are registered and stable while out_valid && !out_ready.
- Latency: a word accepted at edge N is visible at the output after edge N; out_valid is high in cycle N+1 when the FIFO was empty. No combinational bypass.
- Simultaneous push and pop when non-empty and non-full: occupancy unchanged, order preserved.
- Pointers wrap modulo DEPTH. An occupancy counter of width clog2(DEPTH)+1 distinguishes full from empty.
- State machine:
  - RUN → HALT_WAIT when an accepted word has opcode 6'h3F (HALT), any fmt 0–2. The HALT word itself is pushed.
  - HALT_WAIT: in_ready=0. Go to DONE on the edge where the HALT word pops.
  - DONE: done=1, in_ready=0, out_valid=0.
  - DONE → RUN on clear.
- clear in any state: FIFO flushed, out_addr=BASE_ADDR, word_count=0, err=0, state=RUN. clear overrides a same-cycle push or pop.
- Reset values, next cycle after RST: in_ready=1, out_valid=0, imemload=0, out_addr=BASE_ADDR, word_count=0, err=0, done=0, state=RUN, FIFO empty.
- Reset mid-stream drops all buffered words. RST has priority over clear.

Optional Feature:
- Macro INSTR_ENCODER_PARITY_EN adds output port out_parity (1 bit), stored per entry alongside each word.
  - Defined: out_parity = ^imemload (even parity), valid with out_valid, 0 at reset.
  - Undefined: the port is absent and no parity storage is built.

Test Plan:
- Reset then push R-type {fmt=0,op=0,rs=1,rt=2,rd=3,shamt=0,func=6'h21} with out_ready=1 → next cycle out_valid=1, imemload=32'h0022_1821, out_addr=0; after pop word_count=1.
- I-type {op=6'h08,rs=1,rt=2,imm=16'hFFFF} then J-type {op=6'h02,jaddr=26'h0000010} with out_ready=0 → imemload=32'h2022_FFFF held stable; after two pops the second word is 32'h0800_0010 at out_addr=4.
- Push DEPTH+1 words with out_ready=0 → in_ready=0 after the 4th accept; raise out_ready and drain → 4 words in order, addresses 0,4,8,12.
- fmt=3 bundle → err=1, no output word, in_ready stays 1; clear → err=0.
- Push ADDU, then HALT {fmt=2,op=6'h3F} → in_ready=0 after the HALT accept; after both pop, done=1 and word_count=2; clear → done=0, in_ready=1, out_addr=0.
- With 3 words buffered, assert RST for one cycle → out_valid=0, word_count=0, out_addr=BASE_ADDR next cycle.
